// File: rtl/pkt_pkg.sv
// Shared types and helpers for the router packet source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_pkg;

    localparam int         PKT_LEN_W  = 4;
    localparam int         PKT_DEST_W = 2;
    localparam logic [1:0] HDR_PAD    = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_DATA,
        ST_PAR,
        ST_GAP
    } pkt_tx_state_e;

    // Header byte layout on the router bus: pad, length, destination channel.
    function automatic logic [7:0] mk_hdr(input logic [PKT_LEN_W-1:0]  len,
                                          input logic [PKT_DEST_W-1:0] dest);
        return {HDR_PAD, len, dest};
    endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload holding store: 15x8 register file, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is same-cycle.
// Backpressure: none; the caller decides when to write and which entry to read.
module pkt_tx_buf #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_dat,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_dat
);

    localparam int DEPTH = (1 << LEN_W) - 1;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // The all-ones index has no entry behind it; it reads as zero.
    assign rd_dat = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : 8'h00;

endmodule

// File: rtl/pkt_tx.sv
// Packet source: takes a (len, dest) command, buffers L payload bytes, emits hdr/payload/parity back-to-back.
// Latency: header one cycle after the last payload capture (or cmd accept when L=0), then 1 byte/cycle; GAP_CYCLES idle after parity.
// Backpressure: stall freezes the emitted byte, state and counters; PKT_TX_ERR_INJECT_EN adds err_inject to corrupt parity bit0.
module pkt_tx
    import pkt_pkg::*;
#(
    parameter int LEN_W      = PKT_LEN_W,
    parameter int DEST_W     = PKT_DEST_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DEST_W-1:0] cmd_dest,
`ifdef PKT_TX_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              stall,
    output logic [7:0]        pkt_out,
    output logic              pkt_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    pkt_tx_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [7:0]        par_q, par_d;
    logic [2:0]        gap_q, gap_d;
    logic              inj_q, inj_d;
    logic [7:0]        pkt_out_q, pkt_out_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              din_ready_q, din_ready_d;

    logic              buf_we;
    logic [7:0]        buf_rdat;
    logic [7:0]        hdr_cur;
    logic [7:0]        hdr_cmd;
    logic [LEN_W-1:0]  wr_cnt_inc;

    assign hdr_cur    = mk_hdr(len_q, dest_q);
    assign hdr_cmd    = mk_hdr(cmd_len, cmd_dest);
    assign wr_cnt_inc = wr_cnt_q + 1'b1;

    pkt_tx_buf #(
        .LEN_W (LEN_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_we),
        .wr_addr (wr_cnt_q),
        .wr_dat  (din),
        .rd_addr (rd_cnt_q),
        .rd_dat  (buf_rdat)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        dest_d      = dest_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        par_d       = par_q;
        gap_d       = gap_q;
        inj_d       = inj_q;
        pkt_out_d   = pkt_out_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d    = cmd_len;
                    dest_d   = cmd_dest;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    par_d    = hdr_cmd;
`ifdef PKT_TX_ERR_INJECT_EN
                    inj_d    = err_inject;
`else
                    inj_d    = 1'b0;
`endif
                    // Zero-length packets skip straight to the header.
                    if (cmd_len == '0) begin
                        state_d     = ST_HDR;
                        pkt_out_d   = hdr_cmd;
                        pkt_valid_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (din_valid) begin
                    buf_we   = 1'b1;
                    par_d    = par_q ^ din;
                    wr_cnt_d = wr_cnt_inc;
                    if (wr_cnt_inc == len_q) begin
                        state_d     = ST_HDR;
                        pkt_out_d   = hdr_cur;
                        pkt_valid_d = 1'b1;
                    end
                end
            end

            // rd_cnt is the index of the next payload byte to put on the bus.
            ST_HDR, ST_DATA: begin
                if (!stall) begin
                    if (rd_cnt_q == len_q) begin
                        state_d   = ST_PAR;
                        pkt_out_d = par_q ^ {7'b0, inj_q};
                    end else begin
                        state_d   = ST_DATA;
                        pkt_out_d = buf_rdat;
                        rd_cnt_d  = rd_cnt_q + 1'b1;
                    end
                end
            end

            ST_PAR: begin
                if (!stall) begin
                    pkt_out_d   = 8'h00;
                    pkt_valid_d = 1'b0;
                    done_d      = 1'b1;
                    gap_d       = GAP_LOAD;
                    state_d     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                pkt_valid_d = 1'b0;
                pkt_out_d   = 8'h00;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        din_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            dest_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            par_q       <= 8'h00;
            gap_q       <= 3'd0;
            inj_q       <= 1'b0;
            pkt_out_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            par_q       <= par_d;
            gap_q       <= gap_d;
            inj_q       <= inj_d;
            pkt_out_q   <= pkt_out_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign din_ready = din_ready_q;
    assign pkt_out   = pkt_out_q;
    assign pkt_valid = pkt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Bench for pkt_tx: directed packets against a byte-list model of the router stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pkt_tx;

    localparam int GAP = 1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_len   = 4'd0;
    logic [1:0] cmd_dest  = 2'd0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       stall     = 1'b0;
    logic [7:0] pkt_out;
    logic       pkt_valid;
    logic       busy;
    logic       done;
`ifdef PKT_TX_ERR_INJECT_EN
    logic       err_inject = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    bit         exp_last[$];
    logic [7:0] got_log[$];
    bit         done_exp    = 1'b0;
    bit         in_pkt      = 1'b0;
    int         a0_seen     = 0;
    int         busy_cycles = 0;
    bit         cur_err     = 1'b0;
    logic [7:0] pay [16];

    always #5 clk = ~clk;

    pkt_tx #(
        .LEN_W      (4),
        .DEST_W     (2),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_dest   (cmd_dest),
`ifdef PKT_TX_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .stall      (stall),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %02h, want %02h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: every byte on the bus must be the head of the expected list; a byte leaves the
    // list on a cycle without stall, and done must follow one cycle after the packet's last byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_last.delete();
            done_exp = 1'b0;
            in_pkt   = 1'b0;
        end else begin
            if (busy === 1'b1) busy_cycles++;
            check("done", done, done_exp);
            done_exp = 1'b0;
            if (in_pkt) check("contiguous", pkt_valid, 1'b1);
            if (pkt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stray_byte: got %02h, want no byte (t=%0t)", pkt_out, $time);
                end else begin
                    check("pkt_out", pkt_out, exp_q[0]);
                    in_pkt = 1'b1;
                    if (pkt_out === 8'hA0) a0_seen++;
                    if (stall === 1'b0) begin
                        got_log.push_back(pkt_out);
                        if (exp_last[0]) begin
                            done_exp = 1'b1;
                            in_pkt   = 1'b0;
                        end
                        void'(exp_q.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [7:0] push_model(input int len, input int dest, input bit err);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = 8'(len * 4 + dest);
        par = hdr;
        exp_q.push_back(hdr);
        exp_last.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            exp_last.push_back(1'b0);
            par = par ^ pay[i];
        end
        if (err) par = par ^ 8'h01;
        exp_q.push_back(par);
        exp_last.push_back(1'b1);
        return hdr;
    endfunction

    task automatic do_cmd(input int len, input int dest);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_len   = 4'(len);
        cmd_dest  = 2'(dest);
`ifdef PKT_TX_ERR_INJECT_EN
        err_inject = cur_err;
`endif
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load_bytes(input int len, input bit bubble);
        for (int i = 0; i < len; i++) begin
            if (bubble && i == 1) begin
                din_valid = 1'b0;
                @(posedge clk); #1;
            end
            din       = pay[i];
            din_valid = 1'b1;
            check("din_ready", din_ready, 1'b1);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit noise, output bit dr_seen);
        int n = 0;
        dr_seen = 1'b0;
        if (noise) begin
            cmd_valid = 1'b1;
            cmd_len   = 4'd5;
            cmd_dest  = 2'd3;
            din_valid = 1'b1;
            din       = 8'hFF;
        end
        while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < 200) begin
            if (din_ready === 1'b1) dr_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        din_valid = 1'b0;
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic send_pkt(input int len, input int dest, input bit err, input bit bubble,
                            input bit stall_data, input bit noise);
        logic [7:0] hdr;
        int         b0;
        bit         dr;
        hdr     = push_model(len, dest, err);
        cur_err = err;
        b0      = busy_cycles;
        do_cmd(len, dest);
        load_bytes(len, bubble);
        stall = 1'b0;
        check("hdr_visible", pkt_valid, 1'b1);
        check("hdr_value", pkt_out, hdr);
        if (stall_data) begin
            @(posedge clk); #1;
            stall = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            stall = 1'b0;
        end
        wait_idle(noise, dr);
        if (len == 0) check("din_ready_unused", dr, 1'b0);
        check("occupancy", 8'(busy_cycles - b0),
              8'(2 * len + 2 + GAP + int'(bubble) + 3 * int'(stall_data)));
    endtask

    task automatic check_seq(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] lit [5];
        logic [7:0] g;
        lit = '{b0, b1, b2, b3, b4};
        check({name, "_len"}, 8'(got_log.size()), 8'(n));
        for (int i = 0; i < n; i++) begin
            g = (i < got_log.size()) ? got_log[i] : 8'hxx;
            check({name, "_byte"}, g, lit[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #1;
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_out", pkt_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_din_ready", din_ready, 1'b0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // L=2, dest=0, no stall, with ignored cmd/din noise while busy
        got_log.delete();
        pay[0] = 8'hA0; pay[1] = 8'hA1;
        send_pkt(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_seq("t1", 4, 8'h08, 8'hA0, 8'hA1, 8'h09, 8'h00);

        // L=3, dest=1, din bubble, stall held through IDLE/LOAD
        got_log.delete();
        pay[0] = 8'hB0; pay[1] = 8'hB1; pay[2] = 8'hB2;
        stall = 1'b1;
        send_pkt(3, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_seq("t2", 5, 8'h0D, 8'hB0, 8'hB1, 8'hB2, 8'hBE);

        // L=0, dest=3
        got_log.delete();
        send_pkt(0, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        check_seq("t3", 2, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00);

        // L=1, dest=2, 3-cycle stall on the payload byte
        got_log.delete();
        a0_seen = 0;
        pay[0] = 8'hA0;
        send_pkt(1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        check_seq("t4", 3, 8'h06, 8'hA0, 8'hA6, 8'h00, 8'h00);
        check("t4_a0_held", 8'(a0_seen), 8'd4);

        // reset while the second payload byte is on the bus
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        void'(push_model(3, 2, 1'b0));
        cur_err = 1'b0;
        do_cmd(3, 2);
        load_bytes(3, 1'b0);
        n = 0;
        while (!(pkt_valid === 1'b1 && pkt_out === 8'h22) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_reached_data", pkt_out, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pkt_valid", pkt_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        check("midrst_done", done, 1'b0);
        @(posedge clk); #1;
        check("midrst_hold_valid", pkt_valid, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_cmd_ready_after", cmd_ready, 1'b1);
        got_log.delete();
        pay[0] = 8'hC0; pay[1] = 8'hC1;
        send_pkt(2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_seq("t5", 4, 8'h09, 8'hC0, 8'hC1, 8'h08, 8'h00);

        // maximum length packet
        got_log.delete();
        for (int i = 0; i < 15; i++) pay[i] = 8'(i * 17 + 3);
        send_pkt(15, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_len", 8'(got_log.size()), 8'd17);
        if (got_log.size() > 0) check("t6_hdr", got_log[0], 8'h3C);

`ifdef PKT_TX_ERR_INJECT_EN
        got_log.delete();
        pay[0] = 8'hA0; pay[1] = 8'hA1;
        send_pkt(2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_seq("t7", 4, 8'h08, 8'hA0, 8'hA1, 8'h08, 8'h00);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("model_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_tx.md
Name: pkt_tx

Overview:
Packet source for the router's input port. It accepts a command (length, destination channel), buffers the payload bytes, then emits one packet contiguously on the router input byte bus: header, L payload bytes, parity. Used as the on-chip or bench-side traffic generator facing the router receiver. Honours router back-pressure and inserts an inter-packet gap.

Parameters:
LEN_W, 4, width of length field; max payload = 2**LEN_W-1 bytes (15)
DEST_W, 2, width of destination channel field
GAP_CYCLES, 1, idle cycles (pkt_valid=0) forced after each parity byte; legal range 0..7

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  payload byte count L, 0..15
cmd_dest  in  DEST_W  destination channel
din  in  8  payload byte
din_valid  in  1  payload byte valid
din_ready  out  1  high only in LOAD
stall  in  1  router busy; freezes emission
pkt_out  out  8  packet byte to router
pkt_valid  out  1  pkt_out carries a packet byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after parity byte accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pkt_out=0, pkt_valid=0, done=0, busy=0, cmd_ready=0 during reset then 1; counters, parity and buffer pointers cleared. Reset mid-packet truncates the packet immediately; there is no recovery byte.
- Header byte = {2'b00, len[3:0], dest[1:0]} (zero-padded above LEN_W+DEST_W). Parity = XOR of header and all payload bytes.
- FSM states: IDLE, LOAD, HDR, DATA, PAR, GAP.
- IDLE: on cmd_valid&cmd_ready, latch len and dest. Next state is LOAD, or HDR if len=0.
- LOAD: din_ready=1; each din_valid writes buf[wr_cnt] and increments wr_cnt. Bubbles are allowed. After the L-th byte, go to HDR. Buffer depth = 2**LEN_W-1 entries (sub-module).
- HDR/DATA/PAR: pkt_out and pkt_valid are registered, Moore style. The header appears in the cycle after the last payload capture, or the cycle after cmd accept when L=0.
  - A byte is accepted on a clock edge where stall=0. The next byte is then loaded, so the stream is contiguous: 1 byte per cycle when unstalled.
  - stall=1: pkt_out, pkt_valid, state and counters hold.
  - DATA emits buf[0..L-1] in order; PAR emits the accumulated parity.
- After PAR is accepted: done=1 for one cycle and pkt_valid=0.
  - If GAP_CYCLES=0, return to IDLE.
  - Otherwise, GAP counts GAP_CYCLES cycles (stall ignored), then IDLE.
- Min packet occupancy from cmd accept: L (load) + 1 + L + 1 + GAP_CYCLES cycles.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored (not queued).
  - din_valid outside LOAD is ignored.
  - stall in IDLE, LOAD or GAP has no effect.
- Parity accumulator resets at cmd accept.

Optional Feature:
Macro PKT_TX_ERR_INJECT_EN.
- Defined: adds input err_inject (1 bit), sampled at cmd accept. If set, the emitted parity byte has bit0 inverted, to exercise router parity-error detection.
- Undefined: no port, parity is always correct.

Decomposition:
- Shared package pkt_pkg holds:
  - LEN_W/DEST_W defaults
  - state enum pkt_tx_state_e
  - header build function mk_hdr(len,dest)
  - constant HDR_PAD=2'b00
- One sub-module, pkt_tx_buf: a 15x8 register file with sync write port and async read port, indexed by wr_cnt/rd_cnt.

Test Plan:
- L=2, dest=0, payload A0,A1, no stall -> pkt_out sequence 08,A0,A1,09 on 4 consecutive pkt_valid cycles; done pulses next cycle; 1 gap cycle.
- L=3, dest=1, payload B0,B1,B2 with a din_valid bubble -> output still contiguous: 0D,B0,B1,B2,BE.
- L=0, dest=3 -> header 03 then parity 03; din_ready never asserted.
- L=1, dest=2, payload A0, stall held 3 cycles during DATA -> A0 held stable with pkt_valid=1 for 4 cycles; sequence 06,A0,A6.
- rst_n low mid-DATA -> pkt_valid=0 asynchronously, cmd_ready=1 after release; next packet is correct from a fresh header.
- With PKT_TX_ERR_INJECT_EN, L=2, dest=0, err_inject=1 -> parity byte 08 instead of 09.
